posit_host_link: RTL

Host-side serial master for the posit arithmetic unit. Accepts one parallel request (two 16-bit posits plus an opcode) and drives the unit's 3-wire serial port (CE/SCLK/DIN): it writes both operands, lets the unit latch its result, then shifts the 16-bit result back in on DOUT. The result is presented on a valid/ready output. The block sits directly upstream of the posit unit, on the same clock, and is its only driver.

---
 rtl/posit_host_link_pkg.sv | 33 +++
 rtl/posit_sclk_gen.sv | 51 +++++
 rtl/posit_host_link.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/posit_host_link_pkg.sv
// posit_host_link_pkg: shared types and constants for the posit host link.
// Holds FSM state encodings, command-byte field positions and frame lengths.
package posit_host_link_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int OP_MSB     = 7;
    localparam int OP_LSB     = 6;
    localparam int DATA_BIT   = 1;
    localparam int SEL_BIT    = 0;
    localparam int WRITE_BITS = 48;
    localparam int READ_BITS  = 16;

    // Command byte announcing one data word for operand slot `sel`.
    function automatic logic [7:0] cmd_byte(
        input logic [1:0] op,
        input logic       sel
    );
        logic [7:0] c;
        c                = '0;
        c[OP_MSB:OP_LSB] = op;
        c[DATA_BIT]      = 1'b1;
        c[SEL_BIT]       = sel;
        return c;
    endfunction

endpackage

// File: rtl/posit_sclk_gen.sv
// posit_sclk_gen: serial-clock generator with a half-period counter.
// Ports: i_clk/i_rst_n; i_en runs the clock, i_clr restarts it low;
// o_sclk (registered), o_bit_start (first low cycle), o_sample and
// o_bit_done (last high cycle), o_low_done (last low cycle).
module posit_sclk_gen
    import posit_host_link_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_sclk,
    output logic o_bit_start,
    output logic o_sample,
    output logic o_bit_done,
    output logic o_low_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en || i_clr) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_last) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_sclk      = r_phase;
    assign o_bit_start = i_en & ~r_phase & (r_cnt == '0);
    assign o_sample    = i_en & r_phase & w_last;
    assign o_bit_done  = i_en & r_phase & w_last;
    assign o_low_done  = i_en & ~r_phase & w_last;

endmodule

// File: rtl/posit_host_link.sv
// posit_host_link: serial master driving the posit unit's CE/SCLK/DIN port.
// Ports: req_* (valid/ready request: op, a, b), resp_* (valid/ready
// result), ce/sclk/din to the unit, dout from the unit. All outputs are
// registered.
module posit_host_link
    import posit_host_link_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic        ce,
    output logic        sclk,
    output logic        din,
    input  logic        dout
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_setup;
    logic          r_tail;
    logic [5:0]    r_bit_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic [47:0]   r_sh_out;
    logic [15:0]   r_sh_in;
    logic          r_ce;
    logic          r_din;
    logic          r_req_ready;
    logic          r_resp_valid;
    logic [15:0]   r_resp_data;

    logic [7:0]    w_cmd_a;
    logic [7:0]    w_cmd_b;
    logic [47:0]   w_load;
    logic [47:0]   w_sh_shift;
    logic [15:0]   w_sh_in_nxt;
    logic          w_accept;
    logic          w_gen_en;
    logic          w_gen_clr;
    logic          w_bit_start;
    logic          w_sample;
    logic          w_bit_done;
    logic          w_low_done;
    logic          w_wr_last;
    logic          w_tail_end;
    logic          w_rd_last;
    logic          w_gap_last;

    assign w_cmd_a     = cmd_byte(req_op, 1'b0);
    assign w_cmd_b     = cmd_byte(req_op, 1'b1);
    assign w_load      = {w_cmd_a, req_a, w_cmd_b, req_b};
    assign w_sh_shift  = r_sh_out << 1;
    assign w_sh_in_nxt = (r_sh_in << 1) | 16'(dout);

    assign w_accept   = (r_state == S_IDLE) & req_valid;
    assign w_wr_last  = w_bit_done
                      & (r_bit_cnt == 6'(WRITE_BITS));
    assign w_tail_end = r_tail & w_low_done;
    assign w_rd_last  = w_bit_done
                      & (r_bit_cnt == 6'(READ_BITS));
    assign w_gap_last = (r_gap_cnt == GW'(GAP - 1));

    // The first WRITE cycle only presents the first DIN bit; the serial
    // clock starts one cycle later.
    assign w_gen_en  = ((r_state == S_WRITE) & ~r_setup)
                     | (r_state == S_READ);
    // Stop the clock low at the end of the write tail so it cannot rise
    // on the way into GAP.
    assign w_gen_clr = w_tail_end;

    posit_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (w_gen_en),
        .i_clr       (w_gen_clr),
        .o_sclk      (sclk),
        .o_bit_start (w_bit_start),
        .o_sample    (w_sample),
        .o_bit_done  (w_bit_done),
        .o_low_done  (w_low_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept)   w_state_nxt = S_WRITE;
            S_WRITE: if (w_tail_end) w_state_nxt = S_GAP;
            S_GAP:   if (w_gap_last) w_state_nxt = S_READ;
            S_READ:  if (w_rd_last)  w_state_nxt = S_DONE;
            S_DONE:  if (resp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe without a decode after the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ce         <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
        end else begin
            r_ce         <= (w_state_nxt == S_WRITE)
                          | (w_state_nxt == S_READ);
            r_req_ready  <= (w_state_nxt == S_IDLE);
            r_resp_valid <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_setup     <= 1'b0;
            r_tail      <= 1'b0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_sh_out    <= '0;
            r_sh_in     <= '0;
            r_din       <= 1'b0;
            r_resp_data <= '0;
        end else begin
            r_setup <= w_accept;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sh_out  <= w_load;
                        r_din     <= w_load[47];
                        r_bit_cnt <= '0;
                        r_tail    <= 1'b0;
                    end
                end
                S_WRITE: begin
                    // The counter holds the 1-based index of the bit in
                    // flight, so it reads WRITE_BITS during the last bit.
                    if (w_bit_start && !r_tail) begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                    end
                    if (w_bit_done) begin
                        r_sh_out <= w_sh_shift;
                        r_din    <= w_sh_shift[47];
                    end
                    if (w_wr_last) begin
                        r_tail <= 1'b1;
                    end
                    if (w_tail_end) begin
                        r_tail    <= 1'b0;
                        r_gap_cnt <= '0;
                        r_din     <= 1'b0;
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt + GW'(1);
                    if (w_gap_last) begin
                        r_bit_cnt <= '0;
                        r_sh_in   <= '0;
                    end
                end
                S_READ: begin
                    if (w_bit_start) begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                    end
                    if (w_sample) begin
                        r_sh_in <= w_sh_in_nxt;
                    end
                    if (w_rd_last) begin
                        r_resp_data <= w_sh_in_nxt;
                    end
                end
                S_DONE: begin
                    r_din <= 1'b0;
                end
                default: begin
                    r_din <= 1'b0;
                end
            endcase
        end
    end

    assign ce         = r_ce;
    assign din        = r_din;
    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;

endmodule
